exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_pkg.sv | 32 +++
 rtl/exec_shift_step.sv | 35 +++
 rtl/exec_unit.sv | 203 ++++++++++++++++++++
 tb/tb_exec_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_unit shared types: opcodes, flag bit positions, FSM states.
// Optional serial shifter is enabled by macro EXEC_SERIAL_SHIFT_EN.
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Opcodes 8..11 are the shift group; op[1:0] picks the kind.
  function automatic logic is_shift_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/exec_shift_step.sv
// One-bit shift/rotate step for the serial shifter.
// Ports: kind (op[1:0]: SLL/SLR/SRL/SRA), val in, nval out, cout = bit shifted out.
module exec_shift_step #(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        kind,
  input  logic [DATA_W-1:0] val,
  output logic [DATA_W-1:0] nval,
  output logic              cout
);

  always_comb begin
    nval = val;
    cout = 1'b0;
    unique case (kind)
      2'd0: begin
        nval = {val[DATA_W-2:0], 1'b0};
        cout = val[DATA_W-1];
      end
      2'd1: begin
        nval = {val[DATA_W-2:0], val[DATA_W-1]};
        cout = val[DATA_W-1];
      end
      2'd2: begin
        nval = {1'b0, val[DATA_W-1:1]};
        cout = val[0];
      end
      2'd3: begin
        nval = {val[DATA_W-1], val[DATA_W-1:1]};
        cout = val[0];
      end
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU + shifter, registered register-file write and {S,Z,C,V}.
// Ports: clock, reset (async low), exec (freeze), in_valid/in_ready, op,
// rdata1/rdata2, shamt, dst -> wflag/wadd/wdata, flags, busy.
// Macro EXEC_SERIAL_SHIFT_EN: shifts with shamt>0 run 1 bit/cycle.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [3:0]        shamt,
  input  logic [ADDR_W-1:0] dst,
  output logic              wflag,
  output logic [ADDR_W-1:0] wadd,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        flags,
  output logic              busy
);

  localparam int MSB = DATA_W - 1;

  state_t state;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W:0]   sll_w;
  logic [DATA_W:0]   srl_w;
  logic [DATA_W:0]   sra_w;
  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] res;
  logic              c;
  logic              v;
  logic              wr;
  logic              upd;
  logic              start;
  logic [3:0]        nf;

  assign in_ready = (state == ST_IDLE) && !exec;

  assign sum   = {1'b0, rdata1} + {1'b0, rdata2};
  assign diff  = rdata1 - rdata2;
  // Extra bit on the shifted-out side holds the last bit lost.
  assign sll_w = {1'b0, rdata1} << shamt;
  assign srl_w = {rdata1, 1'b0} >> shamt;
  assign sra_w = $signed({rdata1, 1'b0}) >>> shamt;
  assign rot   = (rdata1 << shamt)
               | (rdata1 >> (DATA_W - 32'(shamt)));

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    wr  = 1'b0;
    upd = 1'b1;
    unique case (op)
      OP_ADD: begin
        res = sum[MSB:0];
        c   = sum[DATA_W];
        v   = (rdata1[MSB] == rdata2[MSB])
            && (sum[MSB] != rdata1[MSB]);
        wr  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        res = diff;
        c   = rdata1 < rdata2;
        v   = (rdata1[MSB] != rdata2[MSB])
            && (diff[MSB] != rdata1[MSB]);
        wr  = (op == OP_SUB);
      end
      OP_AND: begin
        res = rdata1 & rdata2;
        wr  = 1'b1;
      end
      OP_OR: begin
        res = rdata1 | rdata2;
        wr  = 1'b1;
      end
      OP_XOR: begin
        res = rdata1 ^ rdata2;
        wr  = 1'b1;
      end
      OP_MOV: begin
        res = rdata2;
        wr  = 1'b1;
      end
      OP_SLL: begin
        {c, res} = sll_w;
        wr = 1'b1;
      end
      OP_SLR: begin
        res = rot;
        c   = (shamt != 4'd0) && rot[0];
        wr  = 1'b1;
      end
      OP_SRL: begin
        {res, c} = srl_w;
        wr = 1'b1;
      end
      OP_SRA: begin
        {res, c} = sra_w;
        wr = 1'b1;
      end
      default: upd = 1'b0;
    endcase
    nf         = '0;
    nf[FLAG_S] = res[MSB];
    nf[FLAG_Z] = (res == '0);
    nf[FLAG_C] = c;
    nf[FLAG_V] = v;
  end

`ifdef EXEC_SERIAL_SHIFT_EN
  logic [DATA_W-1:0] acc;
  logic [3:0]        cnt;
  logic [1:0]        kind;
  logic [DATA_W-1:0] step_val;
  logic              step_c;
  logic [3:0]        step_nf;

  exec_shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .kind (kind),
    .val  (acc),
    .nval (step_val),
    .cout (step_c)
  );

  always_comb begin
    step_nf         = '0;
    step_nf[FLAG_S] = step_val[MSB];
    step_nf[FLAG_Z] = (step_val == '0);
    step_nf[FLAG_C] = step_c;
  end

  assign start = is_shift_op(op) && (shamt != 4'd0);
  assign busy  = (state == ST_SHIFT);
`else
  assign start = 1'b0;
  assign busy  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      wflag <= 1'b0;
      wadd  <= '0;
      wdata <= '0;
      flags <= '0;
`ifdef EXEC_SERIAL_SHIFT_EN
      acc   <= '0;
      cnt   <= '0;
      kind  <= '0;
`endif
    end else if (!exec) begin
      wflag <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            wadd <= dst;
            if (start) begin
              state <= ST_SHIFT;
`ifdef EXEC_SERIAL_SHIFT_EN
              acc   <= rdata1;
              cnt   <= shamt;
              kind  <= op[1:0];
`endif
            end else begin
              if (wr) begin
                wflag <= 1'b1;
                wdata <= res;
              end
              if (upd) flags <= nf;
            end
          end
        end
        ST_SHIFT: begin
`ifdef EXEC_SERIAL_SHIFT_EN
          acc <= step_val;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            wflag <= 1'b1;
            wdata <= step_val;
            flags <= step_nf;
          end
`else
          state <= ST_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: vector table plus freeze/reset sequences.
// Serial-shift sequences are included when EXEC_SERIAL_SHIFT_EN is defined.
module tb_exec_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exec = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [15:0] rdata1 = '0;
  logic [15:0] rdata2 = '0;
  logic [3:0]  shamt = '0;
  logic [2:0]  dst = '0;
  logic        wflag;
  logic [2:0]  wadd;
  logic [15:0] wdata;
  logic [3:0]  flags;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  exec_unit #(
    .DATA_W (16),
    .ADDR_W (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .exec     (exec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .shamt    (shamt),
    .dst      (dst),
    .wflag    (wflag),
    .wadd     (wadd),
    .wdata    (wdata),
    .flags    (flags),
    .busy     (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [2:0]  dst;
    logic        wf;
    logic [15:0] wd;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [3:0] o, input logic [15:0] a,
    input logic [15:0] b, input logic [3:0] sh,
    input logic [2:0] d, input logic wf,
    input logic [15:0] wd, input logic [3:0] fl);
    vec_t r;
    r.op = o; r.a = a; r.b = b; r.sh = sh;
    r.dst = d; r.wf = wf; r.wd = wd; r.fl = fl;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] o,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [3:0] sh,
                       input logic [2:0] d);
    in_valid = 1'b1;
    op = o; rdata1 = a; rdata2 = b;
    shamt = sh; dst = d;
  endtask

  int lat;
  int bcnt;
  int pulses;

  initial begin
    // op a b sh dst -> wflag wdata flags{S,Z,C,V}
    vecs.push_back(mk(0, 16'hFFFF, 16'h0001, 0, 3, 1, 16'h0000, 4'b0110));
    vecs.push_back(mk(1, 16'h8000, 16'h0001, 0, 1, 1, 16'h7FFF, 4'b0001));
    vecs.push_back(mk(5, 16'h0001, 16'h0002, 0, 2, 0, 16'h7FFF, 4'b1010));
    vecs.push_back(mk(2, 16'hF0F0, 16'h0FF0, 0, 4, 1, 16'h00F0, 4'b0000));
    vecs.push_back(mk(3, 16'h8000, 16'h0001, 0, 5, 1, 16'h8001, 4'b1000));
    vecs.push_back(mk(4, 16'h1234, 16'h1234, 0, 6, 1, 16'h0000, 4'b0100));
    vecs.push_back(mk(6, 16'h1111, 16'hABCD, 0, 7, 1, 16'hABCD, 4'b1000));
    vecs.push_back(mk(7, 16'h0001, 16'h0001, 0, 0, 0, 16'hABCD, 4'b1000));
    vecs.push_back(mk(0, 16'h7FFF, 16'h0001, 0, 1, 1, 16'h8000, 4'b1001));
    vecs.push_back(mk(12, 16'h0000, 16'h0000, 0, 2, 0, 16'h8000, 4'b1001));
    vecs.push_back(mk(8, 16'h8001, 16'h0000, 0, 3, 1, 16'h8001, 4'b1000));
    vecs.push_back(mk(9, 16'h0000, 16'h0000, 0, 4, 1, 16'h0000, 4'b0100));
`ifndef EXEC_SERIAL_SHIFT_EN
    vecs.push_back(mk(8, 16'h8001, 16'h0000, 1, 5, 1, 16'h0002, 4'b0010));
    vecs.push_back(mk(10, 16'h8001, 16'h0000, 4, 6, 1, 16'h0800, 4'b0000));
    vecs.push_back(mk(11, 16'h8001, 16'h0000, 4, 7, 1, 16'hF800, 4'b1000));
    vecs.push_back(mk(9, 16'h8001, 16'h0000, 1, 1, 1, 16'h0003, 4'b0010));
    vecs.push_back(mk(9, 16'h8001, 16'h0000, 4, 2, 1, 16'h0018, 4'b0000));
    vecs.push_back(mk(10, 16'h0003, 16'h0000, 1, 3, 1, 16'h0001, 4'b0010));
`endif
    vecs.push_back(mk(1, 16'h0005, 16'h0005, 0, 4, 1, 16'h0000, 4'b0100));

    #1;
    chk("rst_wflag", 32'(wflag), 0);
    chk("rst_wadd", 32'(wadd), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 1);

    // Back-to-back: one vector accepted per edge.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].sh, vecs[i].dst);
      step();
      chk($sformatf("v%0d_wflag", i), 32'(wflag), 32'(vecs[i].wf));
      chk($sformatf("v%0d_wadd", i), 32'(wadd), 32'(vecs[i].dst));
      chk($sformatf("v%0d_wdata", i), 32'(wdata), 32'(vecs[i].wd));
      chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].fl));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
    end

    in_valid = 1'b0;
    step();
    chk("idle_wflag", 32'(wflag), 0);
    chk("idle_ready", 32'(in_ready), 1);

    // Frozen transfer is not taken until exec drops.
    drive(0, 16'h0001, 16'h0001, 0, 5);
    exec = 1'b1;
    #1;
    chk("frz_ready", 32'(in_ready), 0);
    step();
    chk("frz_wflag", 32'(wflag), 0);
    chk("frz_wdata", 32'(wdata), 0);
    exec = 1'b0;
    step();
    chk("unfrz_wflag", 32'(wflag), 1);
    chk("unfrz_wdata", 32'(wdata), 16'h0002);
    chk("unfrz_wadd", 32'(wadd), 5);
    in_valid = 1'b0;
    step();
    chk("pulse_end", 32'(wflag), 0);

    // Asynchronous reset away from any edge.
    reset = 1'b0;
    #1;
    chk("arst_wdata", 32'(wdata), 0);
    chk("arst_wadd", 32'(wadd), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 1);

`ifdef EXEC_SERIAL_SHIFT_EN
    // SRA 0x8001 by 4: four busy cycles, then writeback.
    step();
    drive(11, 16'h8001, 16'h0000, 4, 6);
    step();
    in_valid = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!wflag && lat < 20) begin
      if (busy && !in_ready) bcnt++;
      step();
      lat++;
    end
    chk("sra_lat", 32'(lat), 4);
    chk("sra_busy", 32'(bcnt), 4);
    chk("sra_wdata", 32'(wdata), 16'hF800);
    chk("sra_flags", 32'(flags), 4'b1000);
    chk("sra_wadd", 32'(wadd), 6);
    chk("sra_done_busy", 32'(busy), 0);
    chk("sra_done_ready", 32'(in_ready), 1);
    step();
    chk("sra_pulse", 32'(wflag), 0);

    // Same shift with a 3-cycle freeze after the first step.
    drive(11, 16'h8001, 16'h0000, 4, 6);
    step();
    in_valid = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!wflag && lat < 20) begin
      exec = (lat >= 1 && lat < 4);
      if (busy) bcnt++;
      step();
      lat++;
    end
    exec = 1'b0;
    chk("frzsh_lat", 32'(lat), 7);
    chk("frzsh_busy", 32'(bcnt), 7);
    chk("frzsh_wdata", 32'(wdata), 16'hF800);
    chk("frzsh_flags", 32'(flags), 4'b1000);

    // Reset during SHIFT aborts with no writeback.
    step();
    drive(8, 16'h0001, 16'h0000, 8, 2);
    step();
    in_valid = 1'b0;
    step();
    chk("abort_busy_pre", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wflag", 32'(wflag), 0);
    chk("abort_wdata", 32'(wdata), 0);
    chk("abort_flags", 32'(flags), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(in_ready), 1);
    pulses = 0;
    repeat (12) begin
      step();
      if (wflag) pulses++;
    end
    chk("abort_pulses", 32'(pulses), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
